ahb_rr_arbiter: RTL and testbench
=================================

Name: ahb_rr_arbiter

Overview:
- N-master round-robin AHB bus arbiter with fairness limit and lock support.
- Drives one-hot registered grants, the owning master index and the slave select mux control.
- Sits between master request lines and the address/write-data muxes and slave select fabric.
- Replaces fixed-priority granting: no master starves, and ownership hands over back-to-back without an IDLE bubble.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- SEL_W, 2, width of each master's slave-select field.
- MAX_BEATS, 4, completed transfers an owner may run before it must yield to a pending requester (1..255).

Ports:
- hclk  in  1  bus clock.
- hreset  in  1  asynchronous, active-high reset.
- hreq  in  NUM_MASTERS  per-master bus request.
- hlock  in  NUM_MASTERS  per-master locked-sequence request; honoured only for the current owner.
- sel_in  in  NUM_MASTERS*SEL_W  packed slave selects; master i occupies bits [i*SEL_W +: SEL_W].
- hready_out  in  1  ready from the selected slave.
- hresp  in  1  error response from the selected slave (1 = ERROR).
- hgrant  out  NUM_MASTERS  one-hot registered grant.
- hmaster  out  clog2(NUM_MASTERS)  index of the current owner.
- sel  out  SEL_W  slave select of the current owner.
- busy  out  1  high while any master owns the bus.

Behaviour:
- Reset values: hgrant=0, hmaster=0, sel=0, busy=0, state=IDLE, priority pointer=0, beat counter=0.
- Reset takes effect immediately, mid-transfer included.
- tr_done = hready_out & !hresp. err = hready_out & hresp.
- IDLE: at a clock edge with hreq!=0, choose a winner.
  - Winner is the first set bit searching upward from the pointer, wrapping modulo NUM_MASTERS.
  - Next cycle: hgrant=onehot(winner), hmaster=winner, sel=sel_in[winner], busy=1, state=OWN. Grant latency is 1 cycle.
- sel is re-registered from the owner's slice every cycle in OWN.
- OWN, beat counter: increments on tr_done, saturating at MAX_BEATS.
- OWN, release condition is any of:
  - (a) tr_done & !hreq[owner] & !hlock[owner].
  - (b) tr_done & counter reaches MAX_BEATS & another hreq pending & !hlock[owner].
  - (c) err (ERROR forces release regardless of hlock).
- On release:
  - Pointer becomes owner+1 (wraps).
  - Counter clears.
  - Winner is recomputed from the new pointer, excluding the old owner on the release edge.
  - If a winner exists, the grant moves to it the next cycle (state stays OWN).
  - Otherwise all grants drop and state returns to IDLE.
- hlock held by the owner overrides (a) and (b): the owner keeps the bus and the counter stays saturated. (c) still applies.
- If the owner drops hreq while hready_out=0, it keeps the grant until tr_done (the transfer is never cut).
- If counter=MAX_BEATS but no other requester is pending, the owner retains the bus. The counter holds until a competitor appears, then release happens on the next tr_done.
- hgrant is always one-hot or zero. busy = |hgrant.
- Requests arriving in the same cycle as a release are eligible in that arbitration.

Optional Feature:
- Macro: AHB_ARB_TIMEOUT_EN.
- With the macro: parameter TIMEOUT (default 16) and output timeout_irq (1 bit, reset 0) are added.
  - A stall counter increments each OWN cycle with hready_out=0 and clears on hready_out=1.
  - When it reaches TIMEOUT, the bus is force-released as in (c) and timeout_irq pulses high for one cycle.
- Without the macro: no port, no counter. A stalled slave holds the grant indefinitely.

Decomposition:
- Package ahb_arb_pkg holds:
  - the state enum (IDLE, OWN);
  - the default MAX_BEATS and TIMEOUT constants;
  - a function for master-index width.
- Sub-module ahb_rr_pick: combinational rotating-priority encoder.
  - Inputs: request vector, pointer, exclude mask.
  - Outputs: valid, winner index.
  - The arbiter instantiates it once.

Test Plan:
- Reset mid-ownership: assert hreset while hgrant=0100 -> same cycle hgrant=0, sel=0, busy=0; after release hreq=0001 -> hgrant=0001 one cycle later.
- Round-robin fairness: hreq=1111 held, tr_done every cycle, MAX_BEATS=4 -> grants 0001,0010,0100,1000,0001, each held exactly 4 transfers, no idle gap.
- Stall hold: owner 1 drops hreq while hready_out=0 for 3 cycles -> grant held until hready_out=1 & hresp=0, then moves to the pending master 2 next cycle.
- Lock override: owner 0 with hlock=1, hreq=0011, 10 transfers -> hgrant stays 0001; drop hlock -> hgrant=0010 after the next tr_done.
- Error release: owner 2 locked, hresp=1 with hready_out=1 -> grant moves to master 3 next cycle, pointer=3.
- (AHB_ARB_TIMEOUT_EN, TIMEOUT=16) hready_out=0 for 16 cycles -> timeout_irq one-cycle pulse, grant released.

Source files
------------

// File: rtl/ahb_arb_pkg.sv
// Shared types and constants for the AHB round-robin arbiter.
// The optional slave-stall timeout is enabled with AHB_ARB_TIMEOUT_EN.
package ahb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam int DEF_MAX_BEATS = 4;
    localparam int DEF_TIMEOUT   = 16;

    // Master-index width, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational rotating-priority encoder: first requester at or above the
// pointer (wrapping), with an exclude mask to skip the outgoing owner.
module ahb_rr_pick
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0]        i_req,
    input  logic [idx_w(NUM_MASTERS)-1:0] i_ptr,
    input  logic [NUM_MASTERS-1:0]        i_excl,
    output logic                          o_vld,
    output logic [idx_w(NUM_MASTERS)-1:0] o_idx
);

    localparam int IW = idx_w(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] w_cand;

    assign w_cand = i_req & ~i_excl;

    // Scan from the farthest offset down so the nearest candidate wins last.
    always_comb begin
        o_vld = 1'b0;
        o_idx = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (w_cand[(int'(i_ptr) + k) % NUM_MASTERS]) begin
                o_vld = 1'b1;
                o_idx = IW'((int'(i_ptr) + k) % NUM_MASTERS);
            end
        end
    end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// N-master round-robin AHB arbiter with per-owner beat limit and lock support.
// Define AHB_ARB_TIMEOUT_EN to add the slave-stall timeout and timeout_irq.
module ahb_rr_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int SEL_W       = 2,
    parameter int MAX_BEATS   = DEF_MAX_BEATS
`ifdef AHB_ARB_TIMEOUT_EN
    , parameter int TIMEOUT   = DEF_TIMEOUT
`endif
) (
    input  logic                          hclk,
    input  logic                          hreset,
    input  logic [NUM_MASTERS-1:0]        hreq,
    input  logic [NUM_MASTERS-1:0]        hlock,
    input  logic [NUM_MASTERS*SEL_W-1:0]  sel_in,
    input  logic                          hready_out,
    input  logic                          hresp,
    output logic [NUM_MASTERS-1:0]        hgrant,
    output logic [idx_w(NUM_MASTERS)-1:0] hmaster,
    output logic [SEL_W-1:0]              sel,
    output logic                          busy
`ifdef AHB_ARB_TIMEOUT_EN
    , output logic                        timeout_irq
`endif
);

    localparam int         IW   = idx_w(NUM_MASTERS);
    localparam logic [7:0] MAXB = 8'(MAX_BEATS);

    arb_state_t             r_state;
    logic [NUM_MASTERS-1:0] r_hgrant;
    logic [IW-1:0]          r_hmaster;
    logic [IW-1:0]          r_ptr;
    logic [SEL_W-1:0]       r_sel;
    logic [7:0]             r_cnt;

    logic                   w_tr_done;
    logic                   w_err;
    logic [SEL_W-1:0]       w_sel_arr [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] w_owner_oh;
    logic [IW-1:0]          w_owner_nxt;
    logic [7:0]             w_cnt_inc;
    logic                   w_own_req;
    logic                   w_own_lock;
    logic                   w_others;
    logic                   w_timeout;
    logic                   w_release;
    logic [IW-1:0]          w_pick_ptr;
    logic [NUM_MASTERS-1:0] w_pick_excl;
    logic                   w_pick_vld;
    logic [IW-1:0]          w_pick_idx;
    logic [NUM_MASTERS-1:0] w_win_oh;

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_sel
        assign w_sel_arr[g] = sel_in[g*SEL_W +: SEL_W];
    end

    assign w_tr_done   = hready_out & ~hresp;
    assign w_err       = hready_out & hresp;
    assign w_owner_oh  = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << r_hmaster;
    assign w_owner_nxt = (r_hmaster == IW'(NUM_MASTERS - 1)) ? '0 : r_hmaster + 1'b1;
    assign w_cnt_inc   = (r_cnt == MAXB) ? MAXB : r_cnt + 8'd1;
    assign w_own_req   = |(hreq & w_owner_oh);
    assign w_own_lock  = |(hlock & w_owner_oh);
    assign w_others    = |(hreq & ~w_owner_oh);

`ifdef AHB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_stall;
    logic [TW-1:0] w_stall_inc;
    logic          r_irq;

    assign w_stall_inc = r_stall + 1'b1;
    assign w_timeout   = (r_state == OWN) & ~hready_out & (w_stall_inc == TW'(TIMEOUT));
    assign timeout_irq = r_irq;
`else
    assign w_timeout   = 1'b0;
`endif

    // Lock blocks only the voluntary and fairness releases; an error always hands over.
    assign w_release = (r_state == OWN) &
                       ((w_tr_done & ~w_own_req & ~w_own_lock) |
                        (w_tr_done & (w_cnt_inc == MAXB) & w_others & ~w_own_lock) |
                        w_err | w_timeout);

    assign w_pick_ptr  = (r_state == OWN) ? w_owner_nxt : r_ptr;
    assign w_pick_excl = (r_state == OWN) ? w_owner_oh : '0;
    assign w_win_oh    = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << w_pick_idx;

    ahb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_pick (
        .i_req  (hreq),
        .i_ptr  (w_pick_ptr),
        .i_excl (w_pick_excl),
        .o_vld  (w_pick_vld),
        .o_idx  (w_pick_idx)
    );

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state   <= IDLE;
            r_hgrant  <= '0;
            r_hmaster <= '0;
            r_ptr     <= '0;
            r_sel     <= '0;
            r_cnt     <= '0;
`ifdef AHB_ARB_TIMEOUT_EN
            r_stall   <= '0;
            r_irq     <= 1'b0;
`endif
        end else begin
`ifdef AHB_ARB_TIMEOUT_EN
            r_irq <= w_timeout;
`endif
            if (r_state == IDLE) begin
                if (w_pick_vld) begin
                    r_state   <= OWN;
                    r_hgrant  <= w_win_oh;
                    r_hmaster <= w_pick_idx;
                    r_sel     <= w_sel_arr[w_pick_idx];
                    r_cnt     <= '0;
                end
            end else if (w_release) begin
                r_ptr <= w_owner_nxt;
                r_cnt <= '0;
`ifdef AHB_ARB_TIMEOUT_EN
                r_stall <= '0;
`endif
                // Hand straight to the next requester so there is no IDLE bubble.
                if (w_pick_vld) begin
                    r_hgrant  <= w_win_oh;
                    r_hmaster <= w_pick_idx;
                    r_sel     <= w_sel_arr[w_pick_idx];
                end else begin
                    r_state  <= IDLE;
                    r_hgrant <= '0;
                    r_sel    <= '0;
                end
            end else begin
                r_sel <= w_sel_arr[r_hmaster];
                if (w_tr_done) begin
                    r_cnt <= w_cnt_inc;
                end
`ifdef AHB_ARB_TIMEOUT_EN
                r_stall <= hready_out ? '0 : w_stall_inc;
`endif
            end
        end
    end

    assign hgrant  = r_hgrant;
    assign hmaster = r_hmaster;
    assign sel     = r_sel;
    assign busy    = |r_hgrant;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Self-checking bench for ahb_rr_arbiter: directed scenarios plus randomized
// traffic against a behavioural ownership model.
module tb_ahb_rr_arbiter;

    localparam int N  = 4;
    localparam int SW = 2;
    localparam int MB = 4;
    localparam int TO = 16;

    logic          hclk = 1'b0;
    logic          hreset;
    logic [N-1:0]  hreq;
    logic [N-1:0]  hlock;
    logic [N*SW-1:0] sel_in;
    logic          hready_out;
    logic          hresp;
    logic [N-1:0]  hgrant;
    logic [1:0]    hmaster;
    logic [SW-1:0] sel;
    logic          busy;
`ifdef AHB_ARB_TIMEOUT_EN
    logic          timeout_irq;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: who owns the bus, where the search starts, beats used.
    int           m_owner;
    int           m_ptr;
    int           m_beats;
    int           m_stall;
    bit           m_irq;
    logic [N-1:0] m_grant;
    logic [SW-1:0] m_sel;

    ahb_rr_arbiter #(
        .NUM_MASTERS (N),
        .SEL_W       (SW),
        .MAX_BEATS   (MB)
    ) dut (
        .hclk        (hclk),
        .hreset      (hreset),
        .hreq        (hreq),
        .hlock       (hlock),
        .sel_in      (sel_in),
        .hready_out  (hready_out),
        .hresp       (hresp),
        .hgrant      (hgrant),
        .hmaster     (hmaster),
        .sel         (sel),
        .busy        (busy)
`ifdef AHB_ARB_TIMEOUT_EN
        , .timeout_irq (timeout_irq)
`endif
    );

    always #5 hclk = ~hclk;

    function automatic int rr_find(input logic [N-1:0] req, input int start, input int excl);
        for (int k = 0; k < N; k++) begin
            int m;
            m = (start + k) % N;
            if (m != excl && req[m]) return m;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_beats = 0; m_stall = 0; m_irq = 0;
        m_grant = '0; m_sel = '0;
    endtask

    // Advance the model with the inputs present at the coming edge, then clock.
    task automatic step();
        bit done, er, rel;
        int nb;
        m_irq = 0;
        if (m_owner < 0) begin
            if (hreq != '0) begin
                m_owner = rr_find(hreq, m_ptr, -1);
                m_beats = 0;
            end
        end else begin
            done = hready_out && !hresp;
            er   = hready_out && hresp;
            nb   = done ? ((m_beats + 1 > MB) ? MB : m_beats + 1) : m_beats;
            rel  = er
                || (done && !hreq[m_owner] && !hlock[m_owner])
                || (done && nb == MB && ((hreq & ~(4'b0001 << m_owner)) != '0) && !hlock[m_owner]);
`ifdef AHB_ARB_TIMEOUT_EN
            if (!hready_out) m_stall++;
            else m_stall = 0;
            if (m_stall >= TO) begin
                rel = 1;
                m_irq = 1;
            end
`endif
            if (rel) begin
                m_ptr   = (m_owner + 1) % N;
                m_beats = 0;
                m_stall = 0;
                m_owner = rr_find(hreq, m_ptr, m_owner);
            end else begin
                m_beats = nb;
            end
        end
        m_grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        m_sel   = (m_owner >= 0) ? sel_in[m_owner*SW +: SW] : '0;
        @(posedge hclk);
        #1;
    endtask

    task automatic do_reset();
        hreq = '0; hlock = '0; sel_in = '0; hready_out = 1'b1; hresp = 1'b0;
        hreset = 1'b1;
        @(posedge hclk);
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (hgrant !== 4'b0000) begin n_fail++; $display("FAIL rst_hgrant got %b exp 0000", hgrant); end
        n_tests++; if (hmaster !== 2'd0) begin n_fail++; $display("FAIL rst_hmaster got %0d exp 0", hmaster); end
        n_tests++; if (sel !== 2'b00) begin n_fail++; $display("FAIL rst_sel got %b exp 00", sel); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
        sel_in = 8'hFF;
        hready_out = 1'b0;
        hreq = 4'b0100;
        step();
        n_tests++; if (hgrant !== 4'b0100) begin n_fail++; $display("FAIL rst_pre_grant got %b exp 0100", hgrant); end
        n_tests++; if (sel !== 2'b11) begin n_fail++; $display("FAIL rst_pre_sel got %b exp 11", sel); end
        hreset = 1'b1;
        #1;
        n_tests++; if (hgrant !== 4'b0000) begin n_fail++; $display("FAIL rst_async_grant got %b exp 0000", hgrant); end
        n_tests++; if (sel !== 2'b00) begin n_fail++; $display("FAIL rst_async_sel got %b exp 00", sel); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy got %b exp 0", busy); end
        hreq = 4'b0001;
        hready_out = 1'b1;
        #1;
        hreset = 1'b0;
        model_reset();
        step();
        n_tests++; if (hgrant !== 4'b0001) begin n_fail++; $display("FAIL rst_after_grant got %b exp 0001", hgrant); end
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp;
        do_reset();
        hreq = 4'b1111;
        for (int c = 0; c < 17; c++) begin
            step();
            exp = 4'b0001 << ((c / MB) % N);
            n_tests++;
            if (hgrant !== exp) begin
                n_fail++; $display("FAIL fair_c%0d got %b exp %b", c, hgrant, exp);
            end
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        hreq = 4'b0010;
        hready_out = 1'b0;
        step();
        n_tests++; if (hgrant !== 4'b0010) begin n_fail++; $display("FAIL stall_grant got %b exp 0010", hgrant); end
        hreq = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            step();
            n_tests++; if (hgrant !== 4'b0010) begin n_fail++; $display("FAIL stall_hold_c%0d got %b exp 0010", c, hgrant); end
        end
        hready_out = 1'b1;
        step();
        n_tests++; if (hgrant !== 4'b0100) begin n_fail++; $display("FAIL stall_move got %b exp 0100", hgrant); end
        n_tests++; if (hmaster !== 2'd2) begin n_fail++; $display("FAIL stall_hmaster got %0d exp 2", hmaster); end
    endtask

    task automatic test_lock();
        do_reset();
        hreq = 4'b0011;
        hlock = 4'b0001;
        step();
        for (int c = 0; c < 11; c++) begin
            n_tests++; if (hgrant !== 4'b0001) begin n_fail++; $display("FAIL lock_c%0d got %b exp 0001", c, hgrant); end
            if (c < 10) step();
        end
        hlock = 4'b0000;
        step();
        n_tests++; if (hgrant !== 4'b0010) begin n_fail++; $display("FAIL lock_drop got %b exp 0010", hgrant); end
    endtask

    task automatic test_error_release();
        do_reset();
        hreq = 4'b0100;
        hlock = 4'b0100;
        step();
        n_tests++; if (hgrant !== 4'b0100) begin n_fail++; $display("FAIL err_own got %b exp 0100", hgrant); end
        hreq = 4'b1100;
        hresp = 1'b1;
        step();
        n_tests++; if (hgrant !== 4'b1000) begin n_fail++; $display("FAIL err_move got %b exp 1000", hgrant); end
        n_tests++; if (hmaster !== 2'd3) begin n_fail++; $display("FAIL err_hmaster got %0d exp 3", hmaster); end
        hresp = 1'b0;
        hlock = 4'b0000;
    endtask

`ifdef AHB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        hreq = 4'b0001;
        hready_out = 1'b0;
        step();
        for (int c = 0; c < TO - 1; c++) begin
            step();
            n_tests++; if (hgrant !== 4'b0001 || timeout_irq !== 1'b0) begin
                n_fail++; $display("FAIL to_hold_c%0d got grant %b irq %b exp 0001 0", c, hgrant, timeout_irq);
            end
        end
        step();
        n_tests++; if (hgrant !== 4'b0000 || timeout_irq !== 1'b1) begin
            n_fail++; $display("FAIL to_fire got grant %b irq %b exp 0000 1", hgrant, timeout_irq);
        end
        hreq = 4'b0000;
        step();
        n_tests++; if (timeout_irq !== 1'b0) begin n_fail++; $display("FAIL to_pulse got %b exp 0", timeout_irq); end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            hreq       = N'($urandom);
            hlock      = N'($urandom & $urandom & $urandom);
            hready_out = ($urandom_range(0, 3) != 0);
            hresp      = ($urandom_range(0, 7) == 0);
            sel_in     = (N*SW)'($urandom);
            step();
            n_tests++;
            if (hgrant !== m_grant || busy !== (m_owner >= 0) || sel !== m_sel
                || (m_owner >= 0 && hmaster !== 2'(m_owner)) || !$onehot0(hgrant)) begin
                n_fail++;
                $display("FAIL rand_c%0d got grant %b busy %b sel %b hm %0d exp grant %b sel %b owner %0d",
                         c, hgrant, busy, sel, hmaster, m_grant, m_sel, m_owner);
            end
`ifdef AHB_ARB_TIMEOUT_EN
            n_tests++; if (timeout_irq !== m_irq) begin n_fail++; $display("FAIL rand_irq_c%0d got %b exp %b", c, timeout_irq, m_irq); end
`endif
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fairness();
        test_stall_hold();
        test_lock();
        test_error_release();
`ifdef AHB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
